// File: rtl/nanov_spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI memory bus arbiter: FSM state encoding,
// the bus pin bundle and the guard counter sizing helper.
package nanov_spi_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT0 = 2'd1,
      S_GRANT1 = 2'd2,
      S_GUARD  = 2'd3
   } state_t;

   localparam int NUM_PORTS = 2;

   // One side of the SPI memory bus, as seen on the shared pins.
   typedef struct packed {
      logic sel_n;
      logic mosi;
      logic clk_en;
   } spi_bus_t;

   localparam spi_bus_t BUS_IDLE = '{sel_n: 1'b1, mosi: 1'b0, clk_en: 1'b0};

   // Counter must hold CS_HIGH_CYCLES-1; keep at least one bit when the gap is disabled.
   function automatic int guard_width(input int cs_high_cycles);
      if (cs_high_cycles <= 1) begin
         return 1;
      end
      return $clog2(cs_high_cycles + 1);
   endfunction

endpackage

// File: rtl/nanov_spi_bus_arbiter.sv
// Two-port SPI memory bus arbiter: whole-transaction grants, round-robin on ties,
// and an enforced chip-select-high gap after each transaction.
module nanov_spi_bus_arbiter
   import nanov_spi_bus_arbiter_pkg::*;
#(
   parameter int CS_HIGH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   // port 0: CPU fetch/load master
   input  logic       req0,
   output logic       gnt0,
   input  logic       sel0_n,
   input  logic       mosi0,
   input  logic       clk_en0,
   output logic       miso0,
   // port 1: loader/debug master
   input  logic       req1,
   output logic       gnt1,
   input  logic       sel1_n,
   input  logic       mosi1,
   input  logic       clk_en1,
   output logic       miso1,
   // shared bus pins
   output logic       spi_select,
   output logic       spi_out,
   output logic       spi_clk_enable,
   input  logic       spi_data_in,
   output logic       busy,
   output logic [1:0] dbg_state
);

   localparam int GW = guard_width(CS_HIGH_CYCLES);
   localparam logic [GW-1:0] GUARD_LOAD = GW'((CS_HIGH_CYCLES > 0) ? CS_HIGH_CYCLES - 1 : 0);

   // Handshake: reqN is held high for the whole transaction; gntN follows the
   // registered state, so ownership starts the cycle after the request is
   // seen in IDLE and ends on the edge that samples reqN low.

   state_t          state_q, state_d;
   logic [GW-1:0]   guard_q, guard_d;
   logic            rr_last_q, rr_last_d;
   spi_bus_t        port0_bus, port1_bus, bus;

   assign port0_bus = '{sel_n: sel0_n, mosi: mosi0, clk_en: clk_en0};
   assign port1_bus = '{sel_n: sel1_n, mosi: mosi1, clk_en: clk_en1};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         guard_q   <= '0;
         rr_last_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         guard_q   <= guard_d;
         rr_last_q <= rr_last_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      guard_d   = guard_q;
      rr_last_d = rr_last_q;
      case (state_q)
         S_IDLE: begin
            // On a tie the port that did not own the bus last goes first.
            if (req0 && req1) begin
               if (rr_last_q) begin
                  state_d   = S_GRANT0;
                  rr_last_d = 1'b0;
               end else begin
                  state_d   = S_GRANT1;
                  rr_last_d = 1'b1;
               end
            end else if (req0) begin
               state_d   = S_GRANT0;
               rr_last_d = 1'b0;
            end else if (req1) begin
               state_d   = S_GRANT1;
               rr_last_d = 1'b1;
            end
         end
         S_GRANT0: begin
            if (!req0) begin
               if (CS_HIGH_CYCLES == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GUARD;
                  guard_d = GUARD_LOAD;
               end
            end
         end
         S_GRANT1: begin
            if (!req1) begin
               if (CS_HIGH_CYCLES == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GUARD;
                  guard_d = GUARD_LOAD;
               end
            end
         end
         S_GUARD: begin
            if (guard_q == '0) begin
               state_d = S_IDLE;
            end else begin
               guard_d = guard_q - GW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Reset gates the outputs combinationally so the bus is released at once,
   // not one edge later when the state register clears.
   always_comb begin
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      miso0 = 1'b0;
      miso1 = 1'b0;
      busy  = 1'b0;
      bus   = BUS_IDLE;
      if (!rst) begin
         case (state_q)
            S_GRANT0: begin
               gnt0  = 1'b1;
               busy  = 1'b1;
               bus   = port0_bus;
               miso0 = spi_data_in;
            end
            S_GRANT1: begin
               gnt1  = 1'b1;
               busy  = 1'b1;
               bus   = port1_bus;
               miso1 = spi_data_in;
            end
            S_GUARD: begin
               busy = 1'b1;
            end
            default: begin
               busy = 1'b0;
            end
         endcase
      end
   end

   assign spi_select     = bus.sel_n;
   assign spi_out        = bus.mosi;
   assign spi_clk_enable = bus.clk_en;
   assign dbg_state      = state_q;

endmodule
